// File: rtl/benes_req_sequencer.sv
// benes_req_sequencer: latches a request batch, then streams one grant
// index per output handshake, lowest-numbered request first.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   batch handshake, in_req = request vector
//   out_valid/out_ready grant handshake
//   out_idx, out_last   current grant index, final-grant flag
//   grant_cnt           grants completed in the current batch
//   done                one-cycle pulse when a batch finishes
module benes_req_sequencer #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_req,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W:0]   grant_cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W:0]   grant_cnt_q, grant_cnt_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] low_idx;
    logic [N-1:0]     pending_m1;
    logic             one_left;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // p & (p-1) clears the lowest set bit; zero result means one bit left.
    assign pending_m1 = pending_q - {{(N-1){1'b0}}, 1'b1};
    assign one_left   = (pending_q != '0) &&
                        ((pending_q & pending_m1) == '0);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        grant_cnt_d = grant_cnt_q;
        done_d      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_idx     = '0;
        out_last    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    grant_cnt_d = '0;
                    if (in_req != '0) begin
                        pending_d = in_req;
                        state_d   = GRANT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                out_valid = 1'b1;
                out_idx   = low_idx;
                out_last  = one_left;
                if (out_ready) begin
                    pending_d   = pending_q & pending_m1;
                    grant_cnt_d = grant_cnt_q + {{IDX_W{1'b0}}, 1'b1};
                    if (one_left) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            grant_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            grant_cnt_q <= grant_cnt_d;
            done_q      <= done_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_benes_req_sequencer.sv
// tb_benes_req_sequencer: directed literal checks plus randomized traffic
// compared every cycle against a queue-based grant model.
module tb_benes_req_sequencer;

    localparam int N     = 4;
    localparam int IDX_W = $clog2(N);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [N-1:0]     in_req;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic [IDX_W:0]   grant_cnt;
    logic             done;

    int checks   = 0;
    int failures = 0;

    benes_req_sequencer #(.N(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_req    (in_req),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .grant_cnt (grant_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the batch becomes a queue of granted indices in ascending order.
    int q[$];
    int m_cnt  = 0;
    bit m_done = 0;
    bit nd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_cnt  = 0;
            m_done = 0;
        end else begin
            nd = 0;
            if (q.size() == 0) begin
                if (in_valid) begin
                    m_cnt = 0;
                    if (in_req == '0) nd = 1;
                    else
                        for (int i = 0; i < N; i++)
                            if (in_req[i]) q.push_back(i);
                end
            end else if (out_ready) begin
                void'(q.pop_front());
                m_cnt++;
                if (q.size() == 0) nd = 1;
            end
            m_done = nd;
        end
    end

    always @(posedge clk) begin
        bit ev, el;
        int ei;
        #1;
        ev = (q.size() > 0);
        ei = ev ? q[0] : 0;
        el = (q.size() == 1);
        checks++;
        if (out_valid !== ev || in_ready !== !ev || int'(out_idx) != ei ||
            out_last !== el || int'(grant_cnt) != m_cnt || done !== m_done) begin
            failures++;
            $display("FAIL model_cmp t=%0t got v=%b r=%b i=%0d l=%b c=%0d d=%b want v=%b r=%b i=%0d l=%b c=%0d d=%b",
                     $time, out_valid, in_ready, out_idx, out_last, grant_cnt, done,
                     ev, !ev, ei, el, m_cnt, m_done);
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_req    = '0;
        out_ready = 1'b0;
        repeat (2) nclk();
        rst_n = 1'b1;
        nclk();
        lit("rst_valid", out_valid, 0);
        lit("rst_ready", in_ready, 1);
        lit("rst_idx", out_idx, 0);
        lit("rst_cnt", grant_cnt, 0);
        lit("rst_done", done, 0);

        // full batch
        in_valid = 1; in_req = 4'b1111; out_ready = 1;
        nclk();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            lit("full_valid", out_valid, 1);
            lit("full_idx", out_idx, i);
            lit("full_last", out_last, i == 3);
            lit("full_cnt", grant_cnt, i);
            nclk();
        end
        lit("full_done", done, 1);
        lit("full_cnt_end", grant_cnt, 4);
        lit("full_ready", in_ready, 1);
        nclk();
        lit("full_done_off", done, 0);

        // sparse with backpressure
        in_valid = 1; in_req = 4'b1010; out_ready = 0;
        nclk();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            lit("bp_valid", out_valid, 1);
            lit("bp_idx", out_idx, 1);
            lit("bp_last", out_last, 0);
            nclk();
        end
        lit("bp_idx_hold", out_idx, 1);
        out_ready = 1;
        nclk();
        lit("bp_idx3", out_idx, 3);
        lit("bp_last3", out_last, 1);
        nclk();
        lit("bp_done", done, 1);
        lit("bp_cnt", grant_cnt, 2);

        // zero batch
        in_valid = 1; in_req = 4'b0000;
        nclk();
        in_valid = 0;
        lit("zero_done", done, 1);
        lit("zero_valid", out_valid, 0);
        lit("zero_cnt", grant_cnt, 0);
        nclk();
        lit("zero_done_off", done, 0);
        lit("zero_valid2", out_valid, 0);

        // input ignored while busy
        in_valid = 1; in_req = 4'b0100; out_ready = 0;
        nclk();
        in_req = 4'b1111;
        lit("busy_ready", in_ready, 0);
        lit("busy_idx", out_idx, 2);
        lit("busy_last", out_last, 1);
        out_ready = 1;
        nclk();
        lit("busy_done", done, 1);
        lit("busy_ready2", in_ready, 1);
        nclk();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            lit("busy_next_idx", out_idx, i);
            nclk();
        end
        lit("busy_next_cnt", grant_cnt, 4);

        // single request
        in_valid = 1; in_req = 4'b1000;
        nclk();
        in_valid = 0;
        lit("single_idx", out_idx, 3);
        lit("single_last", out_last, 1);
        nclk();
        lit("single_done", done, 1);
        lit("single_cnt", grant_cnt, 1);

        // reset mid-batch
        in_valid = 1; in_req = 4'b1010; out_ready = 0;
        nclk();
        in_valid = 0;
        lit("mid_valid_pre", out_valid, 1);
        #1 rst_n = 0;
        #1;
        lit("mid_rst_valid", out_valid, 0);
        lit("mid_rst_ready", in_ready, 1);
        lit("mid_rst_cnt", grant_cnt, 0);
        lit("mid_rst_done", done, 0);
        nclk();
        rst_n = 1;
        out_ready = 1;
        repeat (2) begin
            nclk();
            lit("mid_no_stale", out_valid, 0);
            lit("mid_no_done", done, 0);
        end

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_req    = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (i == 1500) begin
                #1 rst_n = 0;
                #2 rst_n = 1;
            end
            nclk();
        end

        in_valid = 0;
        nclk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
